// File: rtl/bp_pkg.sv
// bp_pkg: shared defaults, in-flight entry type and training FSM states for bp_train_unit.
package bp_pkg;
   localparam int BP_HIST_LEN = 16;
   localparam int BP_WEIGHT_W = 8;
   localparam int BP_ROW_W    = 6;
   localparam int BP_THETA    = 44;

   typedef struct packed {
      logic [31:0]            pc;
      logic [BP_HIST_LEN-1:0] hist;
      logic [15:0]            sum;
      logic                   taken;
   } bp_entry_t;

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} bp_state_t;
endpackage

// File: rtl/bp_train_fifo.sv
// bp_train_fifo: in-order DEPTH-entry queue of issued predictions; flush empties it and drops a same-cycle push.
module bp_train_fifo
   import bp_pkg::*;
#(
   parameter int  DEPTH   = 8,
   parameter type entry_t = bp_entry_t
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   push,
   input  logic   pop,
   input  logic   flush,
   input  entry_t din,
   output entry_t dout,
   output logic   full,
   output logic   empty
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   entry_t        mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0]   cnt;
   logic          do_push, do_pop;

   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = cnt == (AW+1)'(DEPTH);
   assign empty   = cnt == '0;
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign dout    = mem[rp];

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else if (flush) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (do_push) wp <= nxt(wp);
         if (do_pop) rp <= nxt(rp);
         cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end

   always_ff @(posedge clk)
      if (do_push) mem[wp] <= din;
endmodule

// File: rtl/bp_train_unit.sv
// bp_train_unit: queues issued perceptron predictions and, on a resolution that needs it, walks the
// weight row read-modify-write for every column; counters exist only with BP_TRAIN_STATS_EN.
module bp_train_unit
   import bp_pkg::*;
#(
   parameter int HIST_LEN = BP_HIST_LEN,
   parameter int WEIGHT_W = BP_WEIGHT_W,
   parameter int ROW_W    = BP_ROW_W,
   parameter int DEPTH    = 8,
   parameter int THETA    = BP_THETA
) (
   input  logic                CLK,
   input  logic                RES,
   input  logic                pred_valid,
   output logic                pred_ready,
   input  logic [31:0]         pred_pc,
   input  logic [HIST_LEN-1:0] pred_hist,
   input  logic [15:0]         pred_sum,
   input  logic                pred_taken,
   input  logic                res_valid,
   output logic                res_ready,
   input  logic                res_taken,
   input  logic                flush,
   output logic                w_req,
   output logic                w_we,
   output logic [ROW_W-1:0]    w_row,
   output logic [4:0]          w_col,
   output logic [WEIGHT_W-1:0] w_wdata,
   input  logic [WEIGHT_W-1:0] w_rdata,
   output logic                busy,
   output logic [31:0]         mispred_cnt,
   output logic [31:0]         train_cnt
);
   localparam int CW = $clog2(HIST_LEN + 1);
   localparam logic [WEIGHT_W-1:0] WMAX = {1'b0, {(WEIGHT_W-1){1'b1}}};
   localparam logic [WEIGHT_W-1:0] WMIN = {1'b1, {(WEIGHT_W-1){1'b0}}};

   typedef struct packed {
      logic [31:0]         pc;
      logic [HIST_LEN-1:0] hist;
      logic [15:0]         sum;
      logic                taken;
   } entry_t;

   entry_t            din, head;
   logic              full, empty, pop, mis, train, up, t, unused;
   logic [16:0]       mag;
   logic [ROW_W-1:0]  row;
   logic [HIST_LEN:0] x;
   logic [CW-1:0]     c;
   bp_state_t         state;

   assign din = {pred_pc, pred_hist, pred_sum, pred_taken};

   bp_train_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
      .clk   (CLK),
      .rst_n (RES),
      .push  (pred_valid && pred_ready),
      .pop   (pop),
      .flush (flush),
      .din   (din),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

   assign pred_ready = !full;
   assign res_ready  = state == IDLE && !empty && !flush;
   assign pop        = res_valid && res_ready;
   assign mis        = res_taken != head.taken;
   // 17-bit magnitude so that -32768 maps to +32768 instead of wrapping
   assign mag        = head.sum[15] ? 17'h0 - {1'b1, head.sum} : {1'b0, head.sum};
   assign train      = mis || mag <= 17'(THETA);
   assign unused     = ^{head.pc[31:ROW_W+2], head.pc[1:0]};

   always_ff @(posedge CLK or negedge RES)
      if (!RES) begin
         state <= IDLE;
         c     <= '0;
         row   <= '0;
         x     <= '0;
         t     <= 1'b0;
      end else case (state)
         IDLE: if (pop && train) begin
            state <= READ;
            c     <= '0;
            row   <= head.pc[ROW_W+1:2];
            x     <= {head.hist, 1'b1};
            t     <= res_taken;
         end
         READ:  state <= WRITE;
         WRITE: begin
            state <= (c == CW'(HIST_LEN)) ? DONE : READ;
            c     <= c + 1'b1;
         end
         default: state <= IDLE;
      endcase

   // x[0] is the constant bias input, x[c] = hist[c-1] otherwise
   assign up      = x[c] == t;
   assign w_req   = state == READ || state == WRITE;
   assign w_we    = state == WRITE;
   assign busy    = state != IDLE;
   assign w_row   = row;
   assign w_col   = 5'(c);
   assign w_wdata = up ? ((w_rdata == WMAX) ? w_rdata : w_rdata + 1'b1)
                       : ((w_rdata == WMIN) ? w_rdata : w_rdata - 1'b1);

`ifdef BP_TRAIN_STATS_EN
   always_ff @(posedge CLK or negedge RES)
      if (!RES) begin
         mispred_cnt <= '0;
         train_cnt   <= '0;
      end else if (pop) begin
         mispred_cnt <= mispred_cnt + 32'(mis);
         train_cnt   <= train_cnt + 32'(train);
      end
`else
   assign mispred_cnt = '0;
   assign train_cnt   = '0;
`endif
endmodule

// File: tb/tb_bp_train_unit.sv
// tb_bp_train_unit: directed scoreboard bench for bp_train_unit; weight accesses are queued as
// expected events and checked by a separate monitor on the falling edge.
module tb_bp_train_unit;
   logic        CLK = 0, RES = 0;
   logic        pred_valid = 0, pred_taken = 0, res_valid = 0, res_taken = 0, flush = 0;
   logic [31:0] pred_pc = 0;
   logic [15:0] pred_hist = 0, pred_sum = 0;
   logic        pred_ready, res_ready, w_req, w_we, busy;
   logic [5:0]  w_row;
   logic [4:0]  w_col;
   logic [7:0]  w_wdata, w_rdata = 0;
   logic [31:0] mispred_cnt, train_cnt;

   typedef struct packed {
      logic       we;
      logic [5:0] row;
      logic [4:0] col;
      logic [7:0] data;
   } ev_t;

   ev_t        sb[$];
   logic [7:0] rd_tab [32];
   int         checks = 0, errors = 0, busy_cyc = 0, exp_mis = 0, exp_train = 0;

   bp_train_unit dut (
      .CLK(CLK), .RES(RES),
      .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_pc(pred_pc),
      .pred_hist(pred_hist), .pred_sum(pred_sum), .pred_taken(pred_taken),
      .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
      .flush(flush),
      .w_req(w_req), .w_we(w_we), .w_row(w_row), .w_col(w_col),
      .w_wdata(w_wdata), .w_rdata(w_rdata),
      .busy(busy), .mispred_cnt(mispred_cnt), .train_cnt(train_cnt)
   );

   always #5 CLK = ~CLK;

   // weight table: read data appears the cycle after the read strobe
   always @(posedge CLK) if (w_req && !w_we) w_rdata <= rd_tab[w_col];

   always @(negedge CLK) begin
      ev_t e;
      if (busy) busy_cyc++;
      if (w_req) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_access got we=%0b row=%0d col=%0d data=%0d, required no access",
                     w_we, w_row, w_col, $signed(w_wdata));
         end else begin
            e = sb.pop_front();
            if (w_we !== e.we || w_row !== e.row || w_col !== e.col || (e.we && w_wdata !== e.data)) begin
               errors++;
               $display("FAIL access got we=%0b row=%0d col=%0d data=%0d, required we=%0b row=%0d col=%0d data=%0d",
                        w_we, w_row, w_col, $signed(w_wdata), e.we, e.row, e.col, $signed(e.data));
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h required=0x%0h", name, got, exp);
      end
   endtask

   task automatic chk_cnt(input string name);
`ifdef BP_TRAIN_STATS_EN
      chk({name, "_mispred_cnt"}, mispred_cnt, exp_mis);
      chk({name, "_train_cnt"}, train_cnt, exp_train);
`else
      chk({name, "_mispred_cnt"}, mispred_cnt, 0);
      chk({name, "_train_cnt"}, train_cnt, 0);
`endif
   endtask

   function automatic logic [7:0] exp_w(input logic [15:0] hist, input logic t, input int c);
      logic        xc = (c == 0) ? 1'b1 : hist[c-1];
      logic signed [7:0] rd = rd_tab[c];
      if (xc == t) return (rd == 8'sd127) ? rd : rd + 8'sd1;
      return (rd == -8'sd128) ? rd : rd - 8'sd1;
   endfunction

   task automatic queue_cols(input logic [31:0] pc, input logic [15:0] hist, input logic t, input int last);
      for (int c = 0; c <= last; c++) begin
         sb.push_back({1'b0, pc[7:2], 5'(c), 8'h00});
         sb.push_back({1'b1, pc[7:2], 5'(c), exp_w(hist, t, c)});
      end
   endtask

   task automatic push(input logic [31:0] pc, input logic [15:0] hist, input logic [15:0] sum);
      pred_valid = 1; pred_pc = pc; pred_hist = hist; pred_sum = sum; pred_taken = !sum[15];
      @(posedge CLK); #1 pred_valid = 0;
   endtask

   task automatic wait_res_ready(input string name);
      int n = 0;
      while (!res_ready && n < 100) begin @(posedge CLK); #1; n++; end
      chk({name, "_res_ready"}, res_ready, 1);
   endtask

   task automatic resolve(input string name, input logic [31:0] pc, input logic [15:0] hist,
                          input logic [15:0] sum, input logic t, input logic tr);
      wait_res_ready(name);
      if (tr) queue_cols(pc, hist, t, 16);
      exp_mis   += int'(t != !sum[15]);
      exp_train += int'(tr);
      busy_cyc = 0;
      res_valid = 1; res_taken = t;
      @(posedge CLK); #1 res_valid = 0;
      repeat (3) @(posedge CLK); #1;
      chk({name, "_busy_mid"}, busy, tr);
      if (tr) chk({name, "_res_ready_busy"}, res_ready, 0);
      repeat (40) @(posedge CLK); #1;
      chk({name, "_busy_cycles"}, busy_cyc, tr ? 35 : 0);
      chk({name, "_pending"}, sb.size(), 0);
      chk_cnt(name);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int i = 0; i < 32; i++) rd_tab[i] = 8'(i * 7 - 40);
      #1;
      chk("rst_w_req", w_req, 0);
      chk("rst_w_we", w_we, 0);
      chk("rst_busy", busy, 0);
      chk("rst_res_ready", res_ready, 0);
      chk("rst_pred_ready", pred_ready, 1);
      chk_cnt("rst");
      repeat (2) @(posedge CLK); #1 RES = 1;
      @(posedge CLK); #1;

      push(32'h104, 16'h0000, 16'd100);
      resolve("strong_correct", 32'h104, 16'h0000, 16'd100, 1, 0);

      push(32'h104, 16'h0001, 16'd100);
      push(32'h2F8, 16'hA5A5, 16'd20);
      resolve("mispredict", 32'h104, 16'h0001, 16'd100, 0, 1);
      resolve("weak_correct", 32'h2F8, 16'hA5A5, 16'd20, 1, 1);

      push(32'h10, 16'h0000, 16'h8000);
      resolve("sum_min", 32'h10, 16'h0000, 16'h8000, 0, 0);
      push(32'h20, 16'h0000, 16'd45);
      resolve("theta_plus1", 32'h20, 16'h0000, 16'd45, 1, 0);

      rd_tab[0] = 8'h7F; rd_tab[1] = 8'h80;
      push(32'h0C, 16'h0000, 16'd44);
      resolve("sat_theta", 32'h0C, 16'h0000, 16'd44, 1, 1);
      rd_tab[0] = 8'h80; rd_tab[2] = 8'h7F;
      push(32'h08, 16'h0000, 16'hFFD4);
      resolve("sat_neg_theta", 32'h08, 16'h0000, 16'hFFD4, 0, 1);

      pred_valid = 1; pred_pc = 32'h40; pred_hist = 16'h1234; pred_sum = 16'd7; pred_taken = 1;
      repeat (8) @(posedge CLK); #1;
      chk("full_pred_ready", pred_ready, 0);
      @(posedge CLK); #1;
      chk("ninth_held", pred_ready, 0);
      flush = 1;
      #1 chk("flush_res_ready", res_ready, 0);
      @(posedge CLK); #1 flush = 0; pred_valid = 0;
      chk("flush_pred_ready", pred_ready, 1);
      chk("flush_empty", res_ready, 0);
      chk("flush_busy", busy, 0);

      push(32'h104, 16'h0001, 16'd100);
      wait_res_ready("rst_mid");
      queue_cols(32'h104, 16'h0001, 0, 5);
      res_valid = 1; res_taken = 0;
      @(posedge CLK); #1 res_valid = 0;
      n = 0;
      do begin @(negedge CLK); n++; end while (!(w_req && w_we && w_col == 5) && n < 100);
      chk("rst_mid_reached_col5", n < 100, 1);
      #2 RES = 0;
      #1;
      chk("rst_mid_w_req", w_req, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_pending", sb.size(), 0);
      exp_mis = 0; exp_train = 0;
      chk_cnt("rst_mid");
      sb.delete();
      repeat (3) @(posedge CLK); #1 RES = 1;
      busy_cyc = 0;
      repeat (50) @(posedge CLK); #1;
      chk("rst_mid_no_resume", busy_cyc, 0);
      chk("rst_mid_pred_ready", pred_ready, 1);
      chk_cnt("rst_after");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
